// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam logic [3:0] REG_PC      = 4'd15;
  localparam int         LDM_MAX_DEF = 16;
  localparam int         LDM_IDX_W   = $clog2(LDM_MAX_DEF);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SWP_WR = 2'd1,
    LDM    = 2'd2,
    FLUSH  = 2'd3
  } fsm_e;

  // A zero count still performs one transfer; larger lists clamp to the sequencer depth.
  function automatic logic [4:0] ldm_cnt_clamp(input logic [4:0] raw, input logic [4:0] max_v);
    logic [4:0] res;
    if (raw == 5'd0) begin
      res = 5'd1;
    end else if (raw > max_v) begin
      res = max_v;
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bus between decode/execute status and the pipeline register controls.
interface pipe_hazard_ctrl_if;

  logic [2:0] id_src_vld;
  logic [3:0] id_rn_code;
  logic [3:0] id_rm_code;
  logic [3:0] id_rs_code;
  logic       ex_rd_vld;
  logic [3:0] ex_rd_code;
  logic       ex_is_load;
  logic       ex_is_swp;
  logic       ex_is_ldm;
  logic [4:0] ex_ldm_cnt;
  logic       ex_pc_wr;
  logic       mem_wait;
  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       swp_phase;
  logic [3:0] ldm_idx;
  logic       busy;

  modport slave (
    input  id_src_vld, id_rn_code, id_rm_code, id_rs_code,
    input  ex_rd_vld, ex_rd_code, ex_is_load, ex_is_swp, ex_is_ldm, ex_ldm_cnt, ex_pc_wr,
    input  mem_wait,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, swp_phase, ldm_idx, busy
  );

  modport master (
    output id_src_vld, id_rn_code, id_rm_code, id_rs_code,
    output ex_rd_vld, ex_rd_code, ex_is_load, ex_is_swp, ex_is_ldm, ex_ldm_cnt, ex_pc_wr,
    output mem_wait,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, swp_phase, ldm_idx, busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: the EX load's destination against the valid ID sources.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [2:0] i_src_vld,
  input  logic [3:0] i_rn_code,
  input  logic [3:0] i_rm_code,
  input  logic [3:0] i_rs_code,
  input  logic       i_ex_rd_vld,
  input  logic [3:0] i_ex_rd_code,
  input  logic       i_ex_is_load,
  output logic       o_load_use
);

  logic w_hit;

  assign w_hit = (i_src_vld[0] && (i_rn_code == i_ex_rd_code)) ||
                 (i_src_vld[1] && (i_rm_code == i_ex_rd_code)) ||
                 (i_src_vld[2] && (i_rs_code == i_ex_rd_code));

  // R15 destinations redirect the PC and are handled by the flush path instead.
  assign o_load_use = i_ex_is_load && i_ex_rd_vld && (i_ex_rd_code != REG_PC) && w_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: stalls, flushes and multi-cycle SWP/LDM sequencing for the ARMv4 core.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LDM_MAX      = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0]           FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [4:0]           LDM_MAX_V  = 5'(LDM_MAX);
  localparam logic [LDM_IDX_W-1:0] IDX_TOP    = LDM_IDX_W'(LDM_MAX - 1);

  fsm_e                 r_fsm,       w_fsm_nxt;
  logic [4:0]           r_ldm_cnt_q, w_ldm_cnt_nxt;
  logic [LDM_IDX_W-1:0] r_ldm_idx,   w_ldm_idx_nxt;
  logic                 r_swp_phase, w_swp_nxt;
  logic [1:0]           r_flush_cnt, w_flush_nxt;

  logic       w_load_use;
  logic [4:0] w_cnt_in;
  logic       w_ldm_last;
  logic       w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
  logic       w_if_id_flush, w_id_ex_flush;

  hazard_detect u_hazard_detect (
    .i_src_vld    (bus.id_src_vld),
    .i_rn_code    (bus.id_rn_code),
    .i_rm_code    (bus.id_rm_code),
    .i_rs_code    (bus.id_rs_code),
    .i_ex_rd_vld  (bus.ex_rd_vld),
    .i_ex_rd_code (bus.ex_rd_code),
    .i_ex_is_load (bus.ex_is_load),
    .o_load_use   (w_load_use)
  );

  assign w_cnt_in   = ldm_cnt_clamp(bus.ex_ldm_cnt, LDM_MAX_V);
  assign w_ldm_last = ({1'b0, r_ldm_idx} == (r_ldm_cnt_q - 5'd1));

  // Control decision and next-state selection, mem_wait first.
  always_comb begin
    w_pc_en       = 1'b1;
    w_if_id_en    = 1'b1;
    w_id_ex_en    = 1'b1;
    w_ex_mem_en   = 1'b1;
    w_mem_wb_en   = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_fsm_nxt     = r_fsm;
    w_ldm_cnt_nxt = r_ldm_cnt_q;
    w_ldm_idx_nxt = r_ldm_idx;
    w_swp_nxt     = r_swp_phase;
    w_flush_nxt   = r_flush_cnt;
    if (bus.mem_wait) begin
      w_pc_en     = 1'b0;
      w_if_id_en  = 1'b0;
      w_id_ex_en  = 1'b0;
      w_ex_mem_en = 1'b0;
      w_mem_wb_en = 1'b0;
    end else begin
      case (r_fsm)
        RUN: begin
          if (bus.ex_pc_wr) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_fsm_nxt   = FLUSH;
              w_flush_nxt = FLUSH_INIT;
            end else begin
              w_fsm_nxt   = RUN;
            end
          end else if (bus.ex_is_swp) begin
            w_pc_en    = 1'b0;
            w_if_id_en = 1'b0;
            w_id_ex_en = 1'b0;
            w_fsm_nxt  = SWP_WR;
            w_swp_nxt  = 1'b1;
          end else if (bus.ex_is_ldm) begin
            w_ldm_cnt_nxt = w_cnt_in;
            if (w_cnt_in != 5'd1) begin
              w_pc_en       = 1'b0;
              w_if_id_en    = 1'b0;
              w_id_ex_en    = 1'b0;
              w_fsm_nxt     = LDM;
              w_ldm_idx_nxt = LDM_IDX_W'(1);
            end else begin
              w_ldm_idx_nxt = '0;
            end
          end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
          end else begin
            w_fsm_nxt = RUN;
          end
        end
        SWP_WR: begin
          w_swp_nxt = 1'b0;
          w_fsm_nxt = RUN;
          if (bus.ex_pc_wr) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_fsm_nxt   = FLUSH;
              w_flush_nxt = FLUSH_INIT;
            end else begin
              w_fsm_nxt   = RUN;
            end
          end else begin
            w_fsm_nxt = RUN;
          end
        end
        LDM: begin
          if (w_ldm_last) begin
            w_ldm_idx_nxt = '0;
            w_fsm_nxt     = RUN;
            if (bus.ex_pc_wr) begin
              w_if_id_flush = 1'b1;
              w_id_ex_flush = 1'b1;
              if (FLUSH_CYCLES > 1) begin
                w_fsm_nxt   = FLUSH;
                w_flush_nxt = FLUSH_INIT;
              end else begin
                w_fsm_nxt   = RUN;
              end
            end else begin
              w_fsm_nxt = RUN;
            end
          end else begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_en    = 1'b0;
            w_ldm_idx_nxt = (r_ldm_idx == IDX_TOP) ? r_ldm_idx : r_ldm_idx + LDM_IDX_W'(1);
          end
        end
        FLUSH: begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          if (r_flush_cnt <= 2'd1) begin
            w_flush_nxt = 2'd0;
            w_fsm_nxt   = RUN;
          end else begin
            w_flush_nxt = r_flush_cnt - 2'd1;
          end
        end
        default: begin
          w_fsm_nxt = RUN;
        end
      endcase
    end
  end

  // Sequencer state; reset drops any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= RUN;
      r_ldm_cnt_q <= 5'd0;
      r_ldm_idx   <= '0;
      r_swp_phase <= 1'b0;
      r_flush_cnt <= 2'd0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_ldm_cnt_q <= w_ldm_cnt_nxt;
      r_ldm_idx   <= w_ldm_idx_nxt;
      r_swp_phase <= w_swp_nxt;
      r_flush_cnt <= w_flush_nxt;
    end
  end

  assign bus.pc_en       = w_pc_en;
  assign bus.if_id_en    = w_if_id_en;
  assign bus.id_ex_en    = w_id_ex_en;
  assign bus.ex_mem_en   = w_ex_mem_en;
  assign bus.mem_wb_en   = w_mem_wb_en;
  assign bus.if_id_flush = w_if_id_flush;
  assign bus.id_ex_flush = w_id_ex_flush;
  assign bus.swp_phase   = r_swp_phase;
  assign bus.ldm_idx     = r_ldm_idx;
  assign bus.busy        = (r_fsm != RUN) ||
                           (!bus.ex_pc_wr && (bus.ex_is_swp || (bus.ex_is_ldm && (w_cnt_in != 5'd1))));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int LDM_MAX = 16;
  localparam int FC      = 2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  // Reference model: sequences described by what remains to be done.
  bit m_in_swp;
  int m_xfers;
  int m_done;
  int m_flush_left;
  bit x_in_swp;
  int x_xfers;
  int x_done;
  int x_flush_left;
  int e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_iff, e_idf, e_swp, e_idx, e_busy;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.LDM_MAX(LDM_MAX), .FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.id_src_vld = 3'b000;
    bus.id_rn_code = 4'd0;
    bus.id_rm_code = 4'd0;
    bus.id_rs_code = 4'd0;
    bus.ex_rd_vld  = 1'b0;
    bus.ex_rd_code = 4'd0;
    bus.ex_is_load = 1'b0;
    bus.ex_is_swp  = 1'b0;
    bus.ex_is_ldm  = 1'b0;
    bus.ex_ldm_cnt = 5'd0;
    bus.ex_pc_wr   = 1'b0;
    bus.mem_wait   = 1'b0;
  endtask

  task automatic model_reset();
    m_in_swp = 1'b0; m_xfers = 0; m_done = 0; m_flush_left = 0;
  endtask

  task automatic freeze_front();
    e_pc = 0; e_ifid = 0; e_idex = 0;
  endtask

  task automatic redirect();
    e_iff = 1; e_idf = 1; x_flush_left = FC - 1;
  endtask

  // Evaluate the expected controls for the present inputs and check every output.
  task automatic eval_and_check();
    int  cnt_in;
    bit  luse;
    bit  in_seq;
    int  rd;
    rd     = int'(bus.ex_rd_code);
    cnt_in = (bus.ex_ldm_cnt == 5'd0) ? 1 : ((int'(bus.ex_ldm_cnt) > LDM_MAX) ? LDM_MAX : int'(bus.ex_ldm_cnt));
    luse   = bus.ex_is_load && bus.ex_rd_vld && (rd != 15) &&
             ((bus.id_src_vld[0] && int'(bus.id_rn_code) == rd) ||
              (bus.id_src_vld[1] && int'(bus.id_rm_code) == rd) ||
              (bus.id_src_vld[2] && int'(bus.id_rs_code) == rd));
    in_seq = m_in_swp || (m_xfers > 0) || (m_flush_left > 0);
    e_pc = 1; e_ifid = 1; e_idex = 1; e_exmem = 1; e_memwb = 1; e_iff = 0; e_idf = 0;
    e_swp  = int'(m_in_swp);
    e_idx  = m_done;
    e_busy = int'(in_seq || (!bus.ex_pc_wr && (bus.ex_is_swp || (bus.ex_is_ldm && cnt_in > 1))));
    x_in_swp = m_in_swp; x_xfers = m_xfers; x_done = m_done; x_flush_left = m_flush_left;
    if (bus.mem_wait) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem = 0; e_memwb = 0;
    end else if (m_flush_left > 0) begin
      e_iff = 1; e_idf = 1; x_flush_left = m_flush_left - 1;
    end else if (m_in_swp) begin
      x_in_swp = 1'b0;
      if (bus.ex_pc_wr) redirect();
    end else if (m_xfers > 0) begin
      if (m_done == m_xfers - 1) begin
        x_xfers = 0; x_done = 0;
        if (bus.ex_pc_wr) redirect();
      end else begin
        freeze_front();
        x_done = m_done + 1;
      end
    end else if (bus.ex_pc_wr) begin
      redirect();
    end else if (bus.ex_is_swp) begin
      freeze_front();
      x_in_swp = 1'b1;
    end else if (bus.ex_is_ldm) begin
      if (cnt_in > 1) begin
        freeze_front();
        x_xfers = cnt_in; x_done = 1;
      end
    end else if (luse) begin
      e_pc = 0; e_ifid = 0; e_idf = 1;
    end
    chk("pc_en",       int'(bus.pc_en),       e_pc);
    chk("if_id_en",    int'(bus.if_id_en),    e_ifid);
    chk("id_ex_en",    int'(bus.id_ex_en),    e_idex);
    chk("ex_mem_en",   int'(bus.ex_mem_en),   e_exmem);
    chk("mem_wb_en",   int'(bus.mem_wb_en),   e_memwb);
    chk("if_id_flush", int'(bus.if_id_flush), e_iff);
    chk("id_ex_flush", int'(bus.id_ex_flush), e_idf);
    chk("swp_phase",   int'(bus.swp_phase),   e_swp);
    chk("ldm_idx",     int'(bus.ldm_idx),     e_idx);
    if (!(bus.mem_wait && !in_seq)) chk("busy", int'(bus.busy), e_busy);
  endtask

  task automatic step();
    @(negedge clk);
    eval_and_check();
    @(posedge clk);
    #1;
    m_in_swp = x_in_swp; m_xfers = x_xfers; m_done = x_done; m_flush_left = x_flush_left;
  endtask

  task automatic randomize_inputs();
    bus.mem_wait   = ($urandom_range(0, 7) == 0);
    bus.ex_pc_wr   = ($urandom_range(0, 9) == 0);
    bus.ex_is_swp  = ($urandom_range(0, 11) == 0);
    bus.ex_is_ldm  = ($urandom_range(0, 7) == 0);
    bus.ex_ldm_cnt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
    bus.ex_is_load = 1'($urandom_range(0, 1));
    bus.ex_rd_vld  = ($urandom_range(0, 3) != 0);
    bus.ex_rd_code = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    bus.id_src_vld = 3'($urandom_range(0, 7));
    bus.id_rn_code = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    bus.id_rm_code = 4'($urandom_range(0, 3));
    bus.id_rs_code = 4'($urandom_range(0, 3));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    set_idle();
    model_reset();
    rst_n = 1'b0;
    #12;
    chk("rst_busy",    int'(bus.busy),      0);
    chk("rst_ldm_idx", int'(bus.ldm_idx),   0);
    chk("rst_swp",     int'(bus.swp_phase), 0);
    chk("rst_pc_en",   int'(bus.pc_en),     1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use on Rm, then a clean cycle.
    bus.ex_is_load = 1'b1; bus.ex_rd_vld = 1'b1; bus.ex_rd_code = 4'd3;
    bus.id_rm_code = 4'd3; bus.id_src_vld = 3'b010;
    step();
    chk("lu_pc_en", int'(bus.pc_en), 0);
    set_idle();
    step();

    // SWP read then write phase.
    bus.ex_is_swp = 1'b1;
    step();
    step();
    set_idle();
    step();

    // Four-transfer LDM with a two-cycle wait at index 1.
    bus.ex_is_ldm = 1'b1; bus.ex_ldm_cnt = 5'd4;
    step();
    bus.mem_wait = 1'b1;
    step();
    step();
    bus.mem_wait = 1'b0;
    for (int i = 0; i < 3; i++) step();
    set_idle();
    step();

    // Degenerate LDM counts behave as ordinary cycles.
    bus.ex_is_ldm = 1'b1; bus.ex_ldm_cnt = 5'd0;
    step();
    bus.ex_ldm_cnt = 5'd1;
    step();
    set_idle();

    // Redirect with a simultaneous load-use: two flush cycles, no stall.
    bus.ex_pc_wr = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd_vld = 1'b1;
    bus.ex_rd_code = 4'd2; bus.id_rn_code = 4'd2; bus.id_src_vld = 3'b001;
    step();
    step();
    set_idle();
    step();

    // Reset in the middle of an LDM.
    bus.ex_is_ldm = 1'b1; bus.ex_ldm_cnt = 5'd5;
    step();
    step();
    chk("pre_rst_idx", int'(bus.ldm_idx), 2);
    set_idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_idx",  int'(bus.ldm_idx), 0);
    chk("mid_rst_busy", int'(bus.busy),    0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the ARMv4 core.
- Drives the enable and bubble/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable.
- Detects load-use hazards, freezes on memory wait, flushes after PC writes, and sequences multi-cycle SWP (read then write) and LDM/STM (N transfers) while the ID/EX register holds the instruction.

Parameters:
- LDM_MAX, 16, maximum transfers per LDM/STM; sets the ldm_idx width to clog2(LDM_MAX).
- FLUSH_CYCLES, 1, number of cycles if_id_flush/id_ex_flush stay asserted after a PC write (1..3).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_src_vld  in  3  valid flags for the Rn/Rm/Rs operands of the instruction in ID.
- id_rn_code  in  4  Rn register number.
- id_rm_code  in  4  Rm register number.
- id_rs_code  in  4  Rs register number.
- ex_rd_vld  in  1  instruction in EX writes Rd.
- ex_rd_code  in  4  Rd register number of the EX instruction.
- ex_is_load  in  1  EX instruction is a single load (LDR/LDRB/LDRH/LDRSx).
- ex_is_swp  in  1  EX instruction is SWP/SWPB.
- ex_is_ldm  in  1  EX instruction is LDM/STM.
- ex_ldm_cnt  in  5  transfer count for LDM/STM (popcount of the register list).
- ex_pc_wr  in  1  EX instruction redirects the PC (branch or write to R15).
- mem_wait  in  1  data memory not ready.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EX register enable.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load bubble into ID/EX.
- swp_phase  out  1  0 = SWP read phase, 1 = SWP write phase.
- ldm_idx  out  4  current LDM/STM transfer index.
- busy  out  1  multi-cycle sequence in progress.

Behaviour:
- Registered state: fsm ∈ {RUN, SWP_WR, LDM, FLUSH}, ldm_cnt_q, ldm_idx, swp_phase, flush_cnt.
- Reset (async, rst_n=0): fsm=RUN, ldm_idx=0, swp_phase=0, flush_cnt=0, ldm_cnt_q=0.
- All control outputs are combinational from the registered state and current inputs. Zero-latency decision: they act on the pipeline registers at the same clock edge.
- Decision priority, highest first:
  1. mem_wait: all enables=0, flushes=0. State, counters and outputs are held.
  2. RUN and ex_pc_wr: all enables=1, if_id_flush=id_ex_flush=1. If FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-1.
  3. RUN and ex_is_swp: swp_phase=0. pc_en, if_id_en and id_ex_en are 0; ex_mem_en and mem_wb_en are 1. Go to SWP_WR.
  4. RUN and ex_is_ldm:
     - Capture cnt = (ex_ldm_cnt==0) ? 1 : min(ex_ldm_cnt, LDM_MAX). ldm_idx=0.
     - If cnt==1: behaves as a normal RUN cycle.
     - Otherwise: front stage frozen as in SWP, go to LDM.
  5. RUN, ex_is_load, ex_rd_vld, and ex_rd_code equals any valid ID source (load-use): pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1. This inserts exactly one bubble.
  6. Otherwise: all enables=1, no flushes.
- SWP_WR:
  - swp_phase=1, all enables=1. Next state RUN.
  - ex_pc_wr here is treated as in RUN: flush, and if FLUSH_CYCLES>1 go to FLUSH.
- LDM:
  - ldm_idx increments by 1 each non-wait cycle.
  - Front stage is frozen while ldm_idx < cnt-1.
  - On ldm_idx == cnt-1 (final transfer): all enables=1. ex_pc_wr is honoured (flush, optional FLUSH). Then ldm_idx=0, return to RUN.
- FLUSH: all enables=1, if_id_flush=id_ex_flush=1. Decrement flush_cnt; return to RUN at 0.
- busy=1 in SWP_WR, LDM, FLUSH, and in the RUN cycle that starts a SWP or a multi-transfer LDM.
- R15 as ex_rd_code never raises a load-use stall; PC writes are covered by ex_pc_wr.
- An async reset mid-sequence aborts it immediately. No partial state survives.
- Counter width: ldm_idx saturates at LDM_MAX-1, so no wrap-around is possible.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - fsm state enum {RUN, SWP_WR, LDM, FLUSH}
  - localparam REG_PC = 4'd15
  - LDM_IDX_W
- One natural sub-module, hazard_detect: combinational load-use comparator over three sources.
- The FSM and counters stay in the top module.

Test Plan:
- Load-use: ex_is_load=1, ex_rd_code=3, id_rm_code=3 with Rm valid -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables=1.
- SWP: ex_is_swp=1 -> cycle 0: swp_phase=0, id_ex_en=0; cycle 1: swp_phase=1, all enables=1, busy=1; cycle 2: RUN, busy=0.
- LDM with ex_ldm_cnt=4, mem_wait pulsed for 2 cycles at ldm_idx=1 -> ldm_idx sequence 0,1,1,1,2,3; id_ex_en=1 only at idx 3; total 6 cycles.
- LDM with ex_ldm_cnt=0 and with ex_ldm_cnt=1 -> single normal cycle, busy=0, ldm_idx stays 0.
- FLUSH_CYCLES=2, ex_pc_wr in RUN -> if_id_flush=id_ex_flush=1 for exactly 2 cycles. The simultaneous load-use condition is ignored (branch wins).
- Assert rst_n=0 at LDM ldm_idx=2 -> immediately RUN, ldm_idx=0, busy=0; after release the first cycle shows all enables=1.
